// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction-cycle sequencer feeding current_state to control.
// Ports: clk, reset, run, step, imem_ack, out_valid, out_ready in.
// Outputs: current_state, imem_req, stall, halted, instr_count, fetch_err.
module cpu_sequencer #(
    parameter int CNT_W         = 16,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             imem_ack,
    input  logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       current_state,
    output logic             imem_req,
    output logic             stall,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic             fetch_err
);

    localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 1);

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    assign imem_req      = (state_q == S_FETCH);
    assign halted        = (state_q == S_RESET);
    assign stall         = (state_q == S_EXEC) && out_valid && !out_ready;
    assign current_state = state_q;
    assign instr_count   = count_q;
    assign fetch_err     = err_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        // Zero outside FETCH so every fetch starts counting from zero.
        wait_d  = '0;
        case (state_q)
            S_RESET: begin
                if (!err_q && (run || step))
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                // Ack takes priority over a timeout in the same cycle.
                if (imem_ack) begin
                    state_d = S_READ;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESET;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_READ: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!stall)
                    state_d = S_WB;
            end
            S_WB: begin
                count_d = count_q + 1'b1;
                state_d = run ? S_FETCH : S_RESET;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            count_q <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed stimulus with queued expectations.
// A negedge monitor pops each expectation and compares all outputs.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset, run, step, imem_ack, out_valid, out_ready;
    logic [2:0] current_state;
    logic       imem_req, stall, halted, fetch_err;
    logic [3:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;
    int tag   = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       stl;
        logic       hlt;
        logic [3:0] cnt;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   tag_q[$];

    cpu_sequencer #(.CNT_W(4), .FETCH_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .step         (step),
        .imem_ack     (imem_ack),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .current_state(current_state),
        .imem_req     (imem_req),
        .stall        (stall),
        .halted       (halted),
        .instr_count  (instr_count),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    // Drive this cycle's inputs and queue the outputs expected during it.
    task automatic cyc(input logic r, input logic s, input logic a,
                       input logic v, input logic y,
                       input logic [2:0] st, input logic [3:0] c,
                       input logic e);
        exp_t x;
        run       = r;
        step      = s;
        imem_ack  = a;
        out_valid = v;
        out_ready = y;
        x.st  = st;
        x.req = (st == 3'd1);
        x.stl = (st == 3'd3) && v && !y;
        x.hlt = (st == 3'd0);
        x.cnt = c;
        x.err = e;
        exp_q.push_back(x);
        tag_q.push_back(tag);
        tag++;
        @(posedge clk);
        #1;
    endtask

    // One unstalled instruction with immediate ack; run level given for WB.
    task automatic instr(input logic [3:0] c, input logic r);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, c, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, c, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, c, 1'b0);
        cyc(r,    1'b0, 1'b0, 1'b0, 1'b0, 3'd4, c, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            int   t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {current_state, imem_req, stall, halted, instr_count, fetch_err};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL vec%0d: got st=%0d req=%0b stl=%0b hlt=%0b cnt=%0d err=%0b, want st=%0d req=%0b stl=%0b hlt=%0b cnt=%0d err=%0b",
                         t, a.st, a.req, a.stl, a.hlt, a.cnt, a.err,
                         e.st, e.req, e.stl, e.hlt, e.cnt, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        run = 0; step = 0; imem_ack = 0; out_valid = 0; out_ready = 0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, 3'd0, 4'd0, 0);
        reset = 1'b0;

        // Continuous run with immediate ack.
        cyc(1, 0, 1, 0, 0, 3'd0, 4'd0, 0);
        instr(4'd0, 1);
        instr(4'd1, 1);
        instr(4'd2, 1);

        // Ack arrives on the 4th fetch cycle.
        repeat (3) cyc(1, 0, 0, 0, 0, 3'd1, 4'd3, 0);
        cyc(1, 0, 1, 0, 0, 3'd1, 4'd3, 0);
        cyc(1, 0, 0, 0, 0, 3'd2, 4'd3, 0);
        cyc(1, 0, 0, 0, 0, 3'd3, 4'd3, 0);
        cyc(1, 0, 0, 0, 0, 4'd4 == 4 ? 3'd4 : 3'd4, 4'd3, 0);

        // Backpressure in EXECUTE for 5 cycles; run drops mid-instruction.
        cyc(1, 0, 1, 0, 0, 3'd1, 4'd4, 0);
        cyc(1, 0, 0, 0, 0, 3'd2, 4'd4, 0);
        cyc(1, 0, 0, 1, 0, 3'd3, 4'd4, 0);
        repeat (4) cyc(0, 0, 0, 1, 0, 3'd3, 4'd4, 0);
        cyc(0, 0, 0, 1, 1, 3'd3, 4'd4, 0);
        cyc(0, 0, 0, 0, 0, 3'd4, 4'd4, 0);

        // Idle ignores a stray ack.
        repeat (2) cyc(0, 0, 1, 0, 0, 3'd0, 4'd5, 0);

        // Single step; later step pulses are ignored.
        cyc(0, 1, 0, 0, 0, 3'd0, 4'd5, 0);
        cyc(0, 0, 1, 0, 0, 3'd1, 4'd5, 0);
        cyc(0, 0, 0, 0, 0, 3'd2, 4'd5, 0);
        cyc(0, 1, 0, 0, 0, 3'd3, 4'd5, 0);
        cyc(0, 1, 0, 0, 0, 3'd4, 4'd5, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 3'd0, 4'd6, 0);

        // Counter wraps 15 -> 0.
        cyc(1, 0, 0, 0, 0, 3'd0, 4'd6, 0);
        for (int i = 0; i < 10; i++)
            instr(4'(6 + i), 1);
        instr(4'd0, 1);
        cyc(1, 0, 1, 0, 0, 3'd1, 4'd1, 0);
        cyc(1, 0, 0, 0, 0, 3'd2, 4'd1, 0);

        // Async reset while in EXECUTE with count=1.
        reset = 1'b1;
        cyc(1, 0, 0, 0, 0, 3'd0, 4'd0, 0);
        cyc(1, 0, 0, 0, 0, 3'd0, 4'd0, 0);
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0, 3'd0, 4'd0, 0);

        // Fetch timeout after 15 cycles; sticky while run/step asserted.
        repeat (15) cyc(1, 0, 0, 0, 0, 3'd1, 4'd0, 0);
        repeat (3) cyc(1, 1, 0, 0, 0, 3'd0, 4'd0, 1);
        reset = 1'b1;
        cyc(1, 0, 0, 0, 0, 3'd0, 4'd0, 0);
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0, 3'd0, 4'd0, 0);

        // Ack on the 15th fetch cycle wins over the timeout.
        repeat (14) cyc(1, 0, 0, 0, 0, 3'd1, 4'd0, 0);
        cyc(1, 0, 1, 0, 0, 3'd1, 4'd0, 0);
        cyc(1, 0, 0, 0, 0, 3'd2, 4'd0, 0);
        cyc(1, 0, 0, 0, 0, 3'd3, 4'd0, 0);
        cyc(0, 0, 0, 0, 0, 3'd4, 4'd0, 0);
        cyc(0, 0, 0, 0, 0, 3'd0, 4'd1, 0);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
